sseg_scan: RTL and testbench
============================

Name: sseg_scan

Overview:
- Downstream consumer of the GPO slot's 16-bit data_out. Drives a 4-digit, common-anode, time-multiplexed seven-segment display on the board.
- Shows the 16-bit word as four hex digits. Scanning uses a prescaled digit rotation with a per-slot blanking interval to suppress ghosting.
- Display inputs are snapshotted once per frame so a digit never tears mid-scan.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot; legal range >= 4.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all outputs off; legal range 1 <= BLANK_CYCLES < SCAN_DIV.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- value  input  16  hex word to display; value[3:0] goes to digit 0, the rightmost digit
- blank_mask  input  4  bit i = 1 turns digit i off
- dp_mask  input  4  bit i = 1 lights the decimal point of digit i
- enable  input  1  0 turns the whole display off
- an  output  4  digit anodes, active-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_start  output  1  one-cycle pulse when a snapshot is taken

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - an=4'hF, seg=7'h7F, dp=1, frame_start=0.
  - cnt=0, digit=0, all snapshot registers 0.
- Slot counter cnt, width $clog2(SCAN_DIV):
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit advances 0->1->2->3->0 (mod 4).
- Phases within a slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt >= BLANK_CYCLES.
- Snapshot:
  - On every edge where the current state is cnt==0 and digit==0, load value, blank_mask, dp_mask and enable into snapshot registers.
  - On that same edge, frame_start is registered to 1; it is 0 on every other edge.
  - The first snapshot therefore occurs on the first edge after reset release.
- Output registration:
  - All outputs are registered, with one cycle of latency from the (cnt, digit, snapshot) state.
  - Input changes outside the snapshot edge have no effect until the next frame.
- Output rule, evaluated on the current state:
  - If the phase is BLANK, or snap_enable==0, or snap_blank[digit]==1: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = ~(4'b0001 << digit), seg = hex decode of snap_value[4*digit +: 4], dp = ~snap_dp[digit].
- Hex decode (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariants:
  - At most one anode is low in any cycle.
  - After reset, an is never low for fewer than SCAN_DIV-BLANK_CYCLES consecutive cycles.
- Frame period is 4*SCAN_DIV cycles, and frame_start pulses exactly once per frame.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). Scanning restarts from digit 0 with a fresh snapshot after release.
- Parameter checks: an elaboration-time assertion fires if BLANK_CYCLES < 1, BLANK_CYCLES >= SCAN_DIV, or SCAN_DIV < 4.

Decomposition:
- Shared package sseg_pkg holds:
  - typedef seg_t (logic [6:0]).
  - Constants SEG_OFF=7'h7F and AN_OFF=4'hF.
  - The 16-entry hex-to-segment constant table.
- One sub-module, hex_to_sseg: purely combinational, 4-bit in, seg_t out, reads the package table.
- sseg_scan holds the counter, digit index, snapshot registers and output registers.

Test Plan:
- Use SCAN_DIV=8, BLANK_CYCLES=2 throughout.
- Reset and first frame: value=16'h1234, masks 0, enable=1, release reset -> frame_start pulses on the first edge.
  - Digit 0 slot: 2 cycles an=F, then 6 cycles an=E, seg=19 (digit 4).
  - Following slots: an=D/seg=30, an=B/seg=24, an=7/seg=79.
- Tearing: change value to 16'hABCD mid-frame at digit 1 -> the remaining digits still show 2,1; the next frame shows D,C,b,A (21,46,03,08).
- Masks: blank_mask=4'b0100, dp_mask=4'b0001 -> digit 2 slot keeps an=F for all 8 cycles; digit 0 drives dp=0; all other digits drive dp=1.
- Enable: enable=0 sampled at frame start -> an=F, seg=7F, dp=1 for the whole 32-cycle frame; frame_start still pulses every 32 cycles.
- Async reset mid-DRIVE: drop reset between edges -> an=F, seg=7F immediately, before the next edge. After release, scanning restarts at digit 0 with a new snapshot.
- Long run of 1000 frames with random value and masks -> assert one-hot-low an, the frame_start period of 32, and seg equal to the decode of the snapshotted nibble.

Source files
------------

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types, off-state constants and hex segment table for the display scanner
package sseg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    localparam seg_t       SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry 15 listed first so HEX_TABLE[n] is digit n.
    localparam seg_t [15:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - combinational hex nibble to active-low seven-segment pattern
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - 4-digit common-anode multiplexed display scanner with per-frame input snapshot
module sseg_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    import sseg_pkg::*;

    localparam int             CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);

    generate
        if (SCAN_DIV < 4 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
            $error("sseg_scan: need SCAN_DIV >= 4 and 1 <= BLANK_CYCLES < SCAN_DIV");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [15:0]   snap_value;
    logic [3:0]    snap_blank;
    logic [3:0]    snap_dp;
    logic          snap_enable;

    phase_t        phase;
    logic          frame_edge;
    logic [3:0]    cur_nibble;
    seg_t          cur_seg;

    logic [3:0]    an_nxt;
    seg_t          seg_nxt;
    logic          dp_nxt;

    assign phase      = (cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    assign frame_edge = (cnt == '0) && (digit == 2'd0);
    assign cur_nibble = snap_value[{digit, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Inputs are frozen for a whole frame so a digit never shows half-old, half-new data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_value  <= '0;
            snap_blank  <= '0;
            snap_dp     <= '0;
            snap_enable <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            if (frame_edge) begin
                snap_value  <= value;
                snap_blank  <= blank_mask;
                snap_dp     <= dp_mask;
                snap_enable <= enable;
            end
        end
    end

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (phase == PH_DRIVE && snap_enable && !snap_blank[digit]) begin
            an_nxt  = ~(4'b0001 << digit);
            seg_nxt = cur_seg;
            dp_nxt  = ~snap_dp[digit];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// tb/tb_sseg_scan.sv - directed and long-run self-checking bench for sseg_scan
module tb_sseg_scan;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h1234;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        enable = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int n_cmp = 0;
    int n_fail = 0;

    sseg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clock       (clock),
        .reset       (reset),
        .value       (value),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
        .enable      (enable),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [15:0] outs();
        return {3'b0, frame_start, an, seg, dp};
    endfunction

    // Expected {fs, an, seg, dp} after the edge at frame position c for a given snapshot.
    function automatic logic [15:0] model(input int c, input logic [15:0] v, input logic [3:0] bm,
                                          input logic [3:0] dm, input logic en);
        int d;
        int k;
        logic fs;
        d  = c / SD;
        k  = c % SD;
        fs = (c == 0);
        if (k < BC || !en || bm[d])
            return {3'b0, fs, 4'hF, 7'h7F, 1'b1};
        return {3'b0, fs, ~(4'b0001 << d), DEC[v[4*d +: 4]], ~dm[d]};
    endfunction

    initial begin
        logic [15:0] sv;
        logic [3:0]  sb;
        logic [3:0]  sdp;
        logic        se;
        int          chg;

        @(negedge clock);
        check("reset_state", outs(), {3'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
        @(negedge clock);
        reset = 1'b1;

        // Frame 1: 1234, value changed to ABCD inside digit 1 must not tear.
        for (int c = 0; c < FRAME; c++) begin
            tick();
            check("frame1", outs(), model(c, 16'h1234, 4'h0, 4'h0, 1'b1));
            if (c == 0)  check("first_fs", {15'b0, frame_start}, 16'd1);
            if (c == 2)  check("d0_drive", {4'b0, an, seg, dp}, {4'b0, 4'hE, 7'h19, 1'b1});
            if (c == 9)  value = 16'hABCD;
            if (c == 10) check("d1_drive", {4'b0, an, seg, dp}, {4'b0, 4'hD, 7'h30, 1'b1});
            if (c == 18) check("d2_notear", {4'b0, an, seg, dp}, {4'b0, 4'hB, 7'h24, 1'b1});
            if (c == 26) check("d3_notear", {4'b0, an, seg, dp}, {4'b0, 4'h7, 7'h79, 1'b1});
        end

        // Frame 2: ABCD; masks set late so they land in frame 3.
        for (int c = 0; c < FRAME; c++) begin
            tick();
            check("frame2", outs(), model(c, 16'hABCD, 4'h0, 4'h0, 1'b1));
            if (c == 2)  check("abcd_d0", {9'b0, seg}, {9'b0, 7'h21});
            if (c == 10) check("abcd_d1", {9'b0, seg}, {9'b0, 7'h46});
            if (c == 18) check("abcd_d2", {9'b0, seg}, {9'b0, 7'h03});
            if (c == 26) check("abcd_d3", {9'b0, seg}, {9'b0, 7'h08});
        end
        blank_mask = 4'b0100;
        dp_mask    = 4'b0001;

        for (int c = 0; c < FRAME; c++) begin
            tick();
            check("frame3_masks", outs(), model(c, 16'hABCD, 4'b0100, 4'b0001, 1'b1));
            if (c == 2)  check("dp_on_d0", {15'b0, dp}, 16'd0);
            if (c == 10) check("dp_off_d1", {15'b0, dp}, 16'd1);
            if (c >= 16 && c < 24) check("d2_blanked", {12'b0, an}, 16'hF);
        end
        enable = 1'b0;

        for (int c = 0; c < FRAME; c++) begin
            tick();
            check("frame4_disabled", outs(), model(c, 16'hABCD, 4'b0100, 4'b0001, 1'b0));
        end
        enable     = 1'b1;
        blank_mask = 4'h0;
        dp_mask    = 4'h0;
        value      = 16'h1234;

        // Async reset while digit 1 is being driven.
        for (int c = 0; c < 12; c++) begin
            tick();
            check("frame5", outs(), model(c, 16'h1234, 4'h0, 4'h0, 1'b1));
        end
        check("pre_reset_drive", {12'b0, an}, 16'hD);
        #2 reset = 1'b0;
        value = 16'h5678;
        #1;
        check("async_reset_off", outs(), {3'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
        @(negedge clock);
        check("held_in_reset", outs(), {3'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
        reset = 1'b1;

        for (int c = 0; c < FRAME; c++) begin
            tick();
            check("after_reset", outs(), model(c, 16'h5678, 4'h0, 4'h0, 1'b1));
        end

        // Long run: inputs change once per frame at a random point.
        for (int f = 0; f < 1000; f++) begin
            sv  = value;
            sb  = blank_mask;
            sdp = dp_mask;
            se  = enable;
            chg = $urandom_range(FRAME - 1, 0);
            for (int c = 0; c < FRAME; c++) begin
                tick();
                check("long_run", outs(), model(c, sv, sb, sdp, se));
                check("onehot_an", {15'b0, ($countones(~an) <= 1)}, 16'd1);
                if (c == chg) begin
                    value      = 16'($urandom);
                    blank_mask = 4'($urandom);
                    dp_mask    = 4'($urandom);
                    enable     = ($urandom_range(7, 0) != 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
